// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (read-only) and load/store (read/write).
// Ports: clk, i_reset (sync, active-high); fetch side i_if_*/o_if_*; load/store side i_ls_*/o_ls_*;
//   memory side o_mem_*/i_mem_*; o_owner reports the current/last grant (0=IF, 1=LS).
// Latency: req -> o_mem_req 1 cycle, i_mem_done -> owner done 1 cycle; one transaction in flight.
// Config macro ARB_ROUND_ROBIN_EN: when defined, ties alternate between requesters and the
//   starvation counter is removed; when undefined, LS wins ties with a starvation guard for IF.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic [XLEN-1:0]   o_if_data,
  output logic              o_if_done,
  input  logic              i_ls_req,
  input  logic              i_ls_write,
  input  logic [XLEN-1:0]   i_ls_addr,
  input  logic [XLEN-1:0]   i_ls_wdata,
  input  logic [XLEN/8-1:0] i_ls_wstrb,
  output logic [XLEN-1:0]   o_ls_rdata,
  output logic              o_ls_done,
  output logic              o_mem_req,
  output logic              o_mem_write,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_mem_done,
  output logic              o_owner
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state_q, state_d;

  logic              if_done_d, ls_done_d, mem_req_d, mem_write_d, owner_d;
  logic [XLEN-1:0]   if_data_d, ls_rdata_d, mem_addr_d, mem_wdata_d;
  logic [XLEN/8-1:0] mem_wstrb_d;
  logic              grant_ls;

`ifndef ARB_ROUND_ROBIN_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;
`endif

  // Winner selection, only meaningful while in IDLE with at least one request.
`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, favour whichever side did not get the previous grant.
  assign grant_ls = i_ls_req && (!i_if_req || !o_owner);
`else
  // LS wins unless IF has waited through STARVE_LIMIT consecutive LS grants.
  assign grant_ls = i_ls_req && !(i_if_req && (starve_q == LIMIT));
`endif

  always_comb begin
    state_d     = state_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_data_d   = o_if_data;
    ls_rdata_d  = o_ls_rdata;
    mem_req_d   = o_mem_req;
    mem_write_d = o_mem_write;
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    mem_wstrb_d = o_mem_wstrb;
    owner_d     = o_owner;
`ifndef ARB_ROUND_ROBIN_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_if_req || i_ls_req) begin
          mem_req_d = 1'b1;
          owner_d   = grant_ls;
          state_d   = BUSY;
          if (grant_ls) begin
            mem_write_d = i_ls_write;
            mem_addr_d  = i_ls_addr;
            mem_wdata_d = i_ls_wdata;
            mem_wstrb_d = i_ls_wstrb;
`ifndef ARB_ROUND_ROBIN_EN
            if (i_if_req && (starve_q != LIMIT)) starve_d = starve_q + 1'b1;
`endif
          end else begin
            // Fetch is read-only: no write, no byte enables, no store data.
            mem_write_d = 1'b0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
`ifndef ARB_ROUND_ROBIN_EN
            starve_d    = '0;
`endif
          end
        end
      end
      BUSY: begin
        if (i_mem_done) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (o_owner) begin
            ls_rdata_d = i_mem_rdata;
            ls_done_d  = 1'b1;
          end else begin
            if_data_d  = i_mem_rdata;
            if_done_d  = 1'b1;
          end
        end
      end
      RESP: begin
        // Requester releases req on the edge leaving RESP, so IDLE sees fresh requests.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      o_if_done   <= 1'b0;
      o_ls_done   <= 1'b0;
      o_if_data   <= '0;
      o_ls_rdata  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_owner     <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      o_if_done   <= if_done_d;
      o_ls_done   <= ls_done_d;
      o_if_data   <= if_data_d;
      o_ls_rdata  <= ls_rdata_d;
      o_mem_req   <= mem_req_d;
      o_mem_write <= mem_write_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_wdata <= mem_wdata_d;
      o_mem_wstrb <= mem_wstrb_d;
      o_owner     <= owner_d;
`ifndef ARB_ROUND_ROBIN_EN
      starve_q    <= starve_d;
`endif
    end
  end

endmodule
